wb_port_arbiter: RTL

Owns the single register-file write port and shares it between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small in-order FIFO. The pipeline has priority; a starvation counter forces the FIFO through by stalling the pipeline. The block sits between the WB stage outputs, the MDU result interface and the register file write port, and exports a pending-destination mask to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a small in-order
// FIFO of MDU results; the pipeline wins unless the FIFO head has starved too long.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_regwrite_i,
    input  logic [4:0]                 wb_rd_i,
    input  logic [XLEN-1:0]            wb_result_i,
    output logic                       wb_stall_o,
    input  logic                       mdu_valid_i,
    input  logic [4:0]                 mdu_rd_i,
    input  logic [XLEN-1:0]            mdu_result_i,
    output logic                       mdu_ready_o,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_rd_o,
    output logic [XLEN-1:0]            rf_wd_o,
    output logic                       rf_src_o,
    output logic [31:0]                pending_mask_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;

    logic            pipe_req;
    logic            fifo_req;
    logic            grant_fifo;
    logic            grant_pipe;
    logic            push_en;
    logic [31:0]     pending_mask;

    // Outputs are gated by rst_n so the port is quiet for the whole reset window.
    always_comb begin
        pipe_req   = wb_regwrite_i && (wb_rd_i != 5'd0);
        fifo_req   = (count_q != '0);
        grant_fifo = rst_n && fifo_req && (!pipe_req || (starve_q >= STARVE_MAX));
        grant_pipe = rst_n && pipe_req && !grant_fifo;

        mdu_ready_o = rst_n && (count_q < CW'(DEPTH));
        push_en     = mdu_valid_i && mdu_ready_o && (mdu_rd_i != 5'd0);
        wb_stall_o  = pipe_req && grant_fifo;

        rf_we_o  = 1'b0;
        rf_rd_o  = 5'd0;
        rf_wd_o  = '0;
        rf_src_o = 1'b0;
        if (grant_fifo) begin
            rf_we_o  = 1'b1;
            rf_rd_o  = rd_mem_q[rd_ptr_q];
            rf_wd_o  = data_mem_q[rd_ptr_q];
            rf_src_o = 1'b1;
        end else if (grant_pipe) begin
            rf_we_o  = 1'b1;
            rf_rd_o  = wb_rd_i;
            rf_wd_o  = wb_result_i;
        end
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;

        if (push_en) begin
            rd_mem_d[wr_ptr_q]   = mdu_rd_i;
            data_mem_d[wr_ptr_q] = mdu_result_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (grant_fifo) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_en && !grant_fifo) begin
            count_d = count_q + CW'(1);
        end else if (!push_en && grant_fifo) begin
            count_d = count_q - CW'(1);
        end

        // The counter measures consecutive losses of the current head only.
        if (grant_fifo || !fifo_req) begin
            starve_d = '0;
        end else if (grant_pipe && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset = PW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) begin
                pending_mask[rd_mem_q[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
        pending_mask_o  = pending_mask;
        fifo_count_o    = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
        end
    end
endmodule
